// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier: op encodings, FSM states
// and the per-op operand signedness helpers.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FIX,
        ST_DONE
    } mul_state_e;

    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input logic [1:0] op);
        return op == MUL_OP_MULH;
    endfunction

    // Every op except MUL returns the upper half of the product.
    function automatic logic op_high_half(input logic [1:0] op);
        return op != MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational sign handling: operand magnitudes and result sign at accept time,
// plus negate and half-select of the unsigned product in the FIX stage.
module mul_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_signed,
    input  logic               b_signed,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               neg,
    input  logic               hi,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               res_neg,
    output logic [WIDTH-1:0]   result
);

    localparam int unsigned PW = 2 * WIDTH;

    logic             a_neg;
    logic             b_neg;
    logic [PW-1:0]    fixed;

    // The most-negative operand maps to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg   = a_signed & a[WIDTH-1];
        b_neg   = b_signed & b[WIDTH-1];
        a_mag   = a_neg ? (WIDTH'(0) - a) : a;
        b_mag   = b_neg ? (WIDTH'(0) - b) : b;
        res_neg = a_neg ^ b_neg;
        fixed   = neg ? (PW'(0) - prod) : prod;
        result  = hi ? fixed[PW-1:WIDTH] : fixed[WIDTH-1:0];
    end

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, retiring
// BITS_PER_CYCLE multiplier bits per BUSY cycle, with flush and a result tag.
module iterative_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);

    mul_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             a_sgn_c, b_sgn_c, hi_c, res_neg_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c, fix_result_c;
    logic [PW-1:0]    partial_c;

    assign a_sgn_c = op_a_signed(in_op);
    assign b_sgn_c = op_b_signed(in_op);
    assign hi_c    = op_high_half(op_q);

    mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a        (in_a),
        .b        (in_b),
        .a_signed (a_sgn_c),
        .b_signed (b_sgn_c),
        .prod     (acc_q),
        .neg      (neg_q),
        .hi       (hi_c),
        .a_mag    (a_mag_c),
        .b_mag    (b_mag_c),
        .res_neg  (res_neg_c),
        .result   (fix_result_c)
    );

    // Shifted multiplicand times the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        partial_c = '0;
        for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
            if (b_q[k]) partial_c = partial_c + (a_sh_q << k);
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        tag_d        = tag_q;
        neg_d        = neg_q;
        a_sh_d       = a_sh_q;
        b_d          = b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = ST_BUSY;
                    op_d    = in_op;
                    tag_d   = in_tag;
                    neg_d   = res_neg_c;
                    a_sh_d  = PW'(a_mag_c);
                    b_d     = b_mag_c;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(N);
                end
            end
            ST_BUSY: begin
                acc_d  = acc_q + partial_c;
                a_sh_d = a_sh_q << BITS_PER_CYCLE;
                b_d    = b_q >> BITS_PER_CYCLE;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                out_result_d = fix_result_c;
                out_tag_d    = tag_q;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                // First DONE cycle raises out_valid; the result was loaded in FIX.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            tag_q        <= '0;
            neg_q        <= 1'b0;
            a_sh_q       <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            neg_q        <= neg_d;
            a_sh_q       <= a_sh_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule
